// File: rtl/servo_seq_ctrl_pkg.sv
// Shared types and constants for the servo sequencing controller.
// Angle codes step in 45-degree increments counter-clockwise from 0.
package servo_pkg;

  localparam int MODE_W       = 3;
  localparam int MODE_MAX_DEF = 4;

  localparam logic [MODE_W-1:0] ANG_0       = 3'd0;
  localparam logic [MODE_W-1:0] ANG_CCW45   = 3'd1;
  localparam logic [MODE_W-1:0] ANG_CCW90   = 3'd2;
  localparam logic [MODE_W-1:0] ANG_CCW135  = 3'd3;
  localparam logic [MODE_W-1:0] ANG_CCW180  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_SWEEP
  } state_t;

endpackage

// File: rtl/servo_seq_ctrl_if.sv
// Command handshake bundle: the requester drives valid/target/sweep,
// the controller answers with ready.
interface servo_seq_ctrl_if;
  import servo_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [MODE_W-1:0] cmd_target;
  logic              cmd_sweep;

  modport master (output cmd_valid, output cmd_target, output cmd_sweep, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_target, input cmd_sweep, output cmd_ready);

endinterface

// File: rtl/servo_seq_ctrl_dwell_timer.sv
// Counts frame ticks and strobes expire on the tick that completes a dwell.
// clr both zeroes the count and masks the strobe, so a clear beats a tick.
module dwell_timer #(
  parameter int DWELL_FRAMES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic expire
);

  localparam logic [7:0] LAST_CNT = 8'(DWELL_FRAMES - 1);

  logic [7:0] cnt_reg;

  assign expire = tick && !clr && (cnt_reg == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= expire ? 8'd0 : cnt_reg + 8'd1;
    end
  end

endmodule

// File: rtl/servo_seq_ctrl.sv
// Servo angle sequencer: accepts move/sweep commands and steps the PWM
// angle code by one position every DWELL_FRAMES frames.
module servo_seq_ctrl
  import servo_pkg::*;
#(
  parameter int DWELL_FRAMES = 10,
  parameter int MODE_MAX     = MODE_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 abort,
  servo_seq_ctrl_if.slave      cmd,
  output logic [MODE_W-1:0]    mode,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [MODE_W-1:0] MODE_TOP = MODE_W'(MODE_MAX);

  state_t            state_reg, state_next;
  logic [MODE_W-1:0] mode_reg, mode_next;
  logic [MODE_W-1:0] target_reg, target_next;
  logic              dir_up_reg, dir_up_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              accept;
  logic              step;
  logic              dwell_clr;
  logic [MODE_W-1:0] stepped;

  assign cmd.cmd_ready = (state_reg == ST_IDLE) && !rst;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign dwell_clr     = (state_reg == ST_IDLE) || abort;
  assign stepped       = dir_up_reg ? mode_reg + 1'b1 : mode_reg - 1'b1;

  dwell_timer #(.DWELL_FRAMES(DWELL_FRAMES)) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .clr    (dwell_clr),
    .tick   (frame_tick),
    .expire (step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      mode_reg   <= ANG_0;
      target_reg <= ANG_0;
      dir_up_reg <= 1'b1;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mode_reg   <= mode_next;
      target_reg <= target_next;
      dir_up_reg <= dir_up_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mode_next   = mode_reg;
    target_next = target_reg;
    dir_up_next = dir_up_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (cmd.cmd_sweep) begin
            dir_up_next = (mode_reg != MODE_TOP);
            state_next  = ST_SWEEP;
          end else if (cmd.cmd_target > MODE_TOP) begin
            err_next = 1'b1;
          end else if (cmd.cmd_target == mode_reg) begin
            done_next = 1'b1;
          end else begin
            target_next = cmd.cmd_target;
            dir_up_next = (cmd.cmd_target > mode_reg);
            state_next  = ST_MOVE;
          end
        end
      end
      ST_MOVE: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (step) begin
          mode_next = stepped;
          if (stepped == target_reg) begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_SWEEP: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (step) begin
          mode_next = stepped;
          // Bounce at either end so the next step heads back the other way.
          if (stepped == MODE_TOP) dir_up_next = 1'b0;
          else if (stepped == ANG_0) dir_up_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign mode = mode_reg;
  assign busy = (state_reg != ST_IDLE);
  assign done = done_reg;
  assign err  = err_reg;

endmodule

// File: doc/servo_seq_ctrl.md
SERVO_SEQ_CTRL -- requirements
Module: servo_seq_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter DWELL_FRAMES, default 10: frame ticks spent at each angle step; legal range 1..255.
REQ-003 Parameter MODE_MAX, default 4: highest legal angle code; 0=0deg, 1=CCW45, 2=CCW90, 3=CCW135, 4=CCW180.
REQ-004 clk  in  1  system clock, 50 MHz.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 frame_tick  in  1  one-cycle pulse per 20 ms PWM frame.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  block accepts a command this cycle.
REQ-009 cmd_target  in  3  target angle code.
REQ-010 cmd_sweep  in  1  1 = continuous sweep command, target ignored.
REQ-011 abort  in  1  stop current motion.
REQ-012 mode  out  3  angle code driven to the PWM generator; registered.
REQ-013 busy  out  1  high in MOVE or SWEEP.
REQ-014 done  out  1  one-cycle pulse when a MOVE reaches its target.
REQ-015 err  out  1  one-cycle pulse on a rejected command.

Function
REQ-016 The FSM SHALL have the states IDLE, MOVE and SWEEP.
REQ-017 cmd_ready SHALL be 1 only in IDLE and when rst=0; a command is accepted on a cycle where cmd_valid and cmd_ready are both 1.
REQ-018 Accepted with cmd_sweep=0 and cmd_target>MODE_MAX: err=1 on the next cycle; state stays IDLE; mode unchanged.
REQ-019 Accepted with cmd_sweep=0 and cmd_target==mode: done=1 on the next cycle; state stays IDLE; no motion.
REQ-020 Accepted with cmd_sweep=0 and any other legal target: the block latches the target, clears the dwell count and enters MOVE on the next cycle.
REQ-021 Accepted with cmd_sweep=1: the block sets the direction up (down if mode==MODE_MAX), clears the dwell count and enters SWEEP.
REQ-022 Dwell: in MOVE or SWEEP, each frame_tick increments the dwell count; the tick on which the count would reach DWELL_FRAMES steps mode by ±1 and resets the count to 0.
REQ-023 Steps occur only on frame_tick cycles; mode never changes by more than 1 per step; the first step occurs on the DWELL_FRAMES-th tick after acceptance.
REQ-024 MOVE direction: +1 if target>mode, else -1; on the step that makes mode==target, done=1 in the same cycle mode updates, and the next state is IDLE.
REQ-025 SWEEP: the block steps toward the current end; on reaching MODE_MAX it reverses to down, and on reaching 0 it reverses to up. SWEEP never asserts done and runs until abort.
REQ-026 abort=1 in MOVE or SWEEP SHALL return the block to IDLE on the next cycle with mode held and no done; abort wins over a coincident frame_tick (no step); abort in IDLE has no effect.
REQ-027 cmd_valid outside IDLE SHALL be ignored (not accepted, not queued).
REQ-028 done and err SHALL never be 1 in the same cycle; busy SHALL equal (state != IDLE).

Reset
REQ-029 Under rst: mode=0, state=IDLE, busy=0, done=0, err=0, cmd_ready=0, dwell count=0, latched target=0, direction=up.
REQ-030 Reset asserted mid-MOVE or mid-SWEEP SHALL abandon motion with no done pulse; cmd_ready=1 on the first cycle after rst deasserts.

Structure
REQ-031 Package servo_pkg SHALL hold the state enum, the MODE_W=3 width constant, the MODE_MAX default and the angle-code constants.
REQ-032 The dwell counter SHALL be a sub-module dwell_timer with ports clk, rst, clr, tick and expire (expire is the step strobe).
REQ-033 The top level SHALL contain only the FSM, the target/direction registers and the mode register.

Verification (DWELL_FRAMES=2, MODE_MAX=4)
REQ-034 Reset, then MOVE target 3 from 0 -> mode 1, 2, 3 on the 2nd, 4th and 6th ticks; done pulses with mode=3; busy drops the next cycle.
REQ-035 cmd_target=6 in IDLE -> err pulses for 1 cycle; mode and state unchanged; cmd_ready stays 1.
REQ-036 cmd_target equal to the current mode (2) -> done on the next cycle; busy never rises.
REQ-037 SWEEP from 3 -> mode 4, 3, 2, 1, 0, 1 on successive step ticks; no done.
REQ-038 abort asserted in the same cycle as a stepping frame_tick during MOVE 0->4 at mode=2 -> mode stays 2, IDLE next cycle, no done; cmd_valid during busy is not accepted.
REQ-039 rst pulsed mid-SWEEP at mode=3 -> mode=0, all outputs 0, cmd_ready=1 on the cycle after release.
